// File: rtl/neuro_emotion_decoder_if.sv
// Bus between the neurotransmitter subsystems and the emotion decoder.
// tick is a one-cycle update strobe with no backpressure; the decoder samples levels only while tick=1.
interface neuro_emotion_decoder_if;
  logic       tick;
  logic [9:0] neurotransmitter_level;
  logic [7:0] emotional_state;
  logic [2:0] emotion_idx;
  logic       state_changed;
  logic       phase_dbg;

  modport master (
    output tick, neurotransmitter_level,
    input  emotional_state, emotion_idx, state_changed, phase_dbg
  );

  modport slave (
    input  tick, neurotransmitter_level,
    output emotional_state, emotion_idx, state_changed, phase_dbg
  );
endinterface

// File: rtl/neuro_emotion_decoder.sv
// Priority-decodes neurotransmitter levels into a one-hot emotion, filtered by persistence and dwell.
// Optional macro EMOTION_STRESS_BYPASS_EN: acute STRESSED (cortisol=3) commits at once.
module neuro_emotion_decoder #(
  parameter int PERSIST   = 4,
  parameter int MIN_DWELL = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  neuro_emotion_decoder_if.slave  bus
);
  typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} phase_t;

  localparam logic [3:0] P_MAX        = 4'(PERSIST);
  localparam logic [7:0] D_MAX        = 8'(MIN_DWELL);
  localparam logic [2:0] IDX_STRESSED = 3'd5;

  phase_t     phase;
  logic [2:0] cand;
  logic [2:0] emo_idx;
  logic [7:0] emo_state;
  logic       changed;
  logic [3:0] persist_cnt;
  logic [7:0] dwell_cnt;

  logic [2:0] new_idx;
  logic [7:0] dwell_next;
  logic [3:0] pnext;
  logic       bypass;
  logic       commit;
  logic [1:0] lc, ld, lg, ln, ls;

  assign lc = bus.neurotransmitter_level[1:0];
  assign ld = bus.neurotransmitter_level[3:2];
  assign lg = bus.neurotransmitter_level[5:4];
  assign ln = bus.neurotransmitter_level[7:6];
  assign ls = bus.neurotransmitter_level[9:8];

  always_comb begin
    if (lc == 2'd3 && ln >= 2'd2)      new_idx = 3'd5;
    else if (lc >= 2'd2 && lg <= 2'd1) new_idx = 3'd4;
    else if (ln == 2'd3 && ls <= 2'd1) new_idx = 3'd7;
    else if (ls == 2'd0 && ld <= 2'd1) new_idx = 3'd6;
    else if (ld == 2'd3 && ln >= 2'd2) new_idx = 3'd2;
    else if (ld >= 2'd2 && ls >= 2'd2) new_idx = 3'd1;
    else if (lg >= 2'd2 && ls >= 2'd2) new_idx = 3'd3;
    else                               new_idx = 3'd0;
  end

  // Both counters saturate, so neither can wrap while waiting.
  always_comb begin
    dwell_next = (dwell_cnt >= D_MAX) ? D_MAX : dwell_cnt + 8'd1;
    if (phase == PENDING && new_idx == cand)
      pnext = (persist_cnt >= P_MAX) ? P_MAX : persist_cnt + 4'd1;
    else
      pnext = 4'd1;
  end

`ifdef EMOTION_STRESS_BYPASS_EN
  assign bypass = (new_idx == IDX_STRESSED) && (lc == 2'd3);
`else
  assign bypass = 1'b0;
`endif

  assign commit = (new_idx != emo_idx) &&
                  (((pnext >= P_MAX) && (dwell_next >= D_MAX)) || bypass);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase       <= STABLE;
      cand        <= 3'd0;
      emo_idx     <= 3'd0;
      emo_state   <= 8'h01;
      changed     <= 1'b0;
      persist_cnt <= 4'd0;
      dwell_cnt   <= 8'd0;
    end else begin
      changed <= 1'b0;
      if (bus.tick) begin
        dwell_cnt <= dwell_next;
        if (new_idx == emo_idx) begin
          phase       <= STABLE;
          persist_cnt <= 4'd0;
        end else if (commit) begin
          cand        <= new_idx;
          emo_idx     <= new_idx;
          emo_state   <= 8'd1 << new_idx;
          dwell_cnt   <= 8'd0;
          persist_cnt <= 4'd0;
          phase       <= STABLE;
          changed     <= 1'b1;
        end else begin
          cand        <= new_idx;
          persist_cnt <= pnext;
          phase       <= PENDING;
        end
      end
    end
  end

  assign bus.emotional_state = emo_state;
  assign bus.emotion_idx     = emo_idx;
  assign bus.state_changed   = changed;
  assign bus.phase_dbg       = (phase == PENDING);
endmodule

// File: tb/tb_neuro_emotion_decoder.sv
// Bench for neuro_emotion_decoder: behavioural model + expected queue, directed and random stimulus.
module tb_neuro_emotion_decoder;
  localparam int PERSIST   = 4;
  localparam int MIN_DWELL = 8;

  localparam logic [9:0] LV_CALM     = 10'h155;
  localparam logic [9:0] LV_HAPPY    = 10'h208;
  localparam logic [9:0] LV_STRESSED = 10'h083;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   armed;
  logic [11:0] exp_q[$];

  neuro_emotion_decoder_if bus();

  neuro_emotion_decoder #(.PERSIST(PERSIST), .MIN_DWELL(MIN_DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int decode(input logic [9:0] lv);
    int c, d, g, n, s;
    c = int'(lv[1:0]); d = int'(lv[3:2]); g = int'(lv[5:4]);
    n = int'(lv[7:6]); s = int'(lv[9:8]);
    if (c == 3 && n >= 2) return 5;
    if (c >= 2 && g <= 1) return 4;
    if (n == 3 && s <= 1) return 7;
    if (s == 0 && d <= 1) return 6;
    if (d == 3 && n >= 2) return 2;
    if (d >= 2 && s >= 2) return 1;
    if (g >= 2 && s >= 2) return 3;
    return 0;
  endfunction

  function automatic bit bypass_hit(input int nw, input logic [9:0] lv);
`ifdef EMOTION_STRESS_BYPASS_EN
    return (nw == 5) && (lv[1:0] == 2'd3);
`else
    return 1'b0 && (nw == 5) && (lv[1:0] == 2'd3);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counts a run of identical differing candidates and ticks since the last commit.
  initial begin
    int cur, run, last, since, nw;
    bit sc;
    cur = 0; run = 0; last = 0; since = 0; sc = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        armed = 1'b1;
        cur = 0; run = 0; since = 0; sc = 1'b0;
      end else if (armed) begin
        sc = 1'b0;
        if (bus.tick) begin
          nw = decode(bus.neurotransmitter_level);
          since++;
          if (nw == cur) begin
            run = 0;
          end else begin
            run  = (run > 0 && nw == last) ? run + 1 : 1;
            last = nw;
            if ((run >= PERSIST && since >= MIN_DWELL) || bypass_hit(nw, bus.neurotransmitter_level)) begin
              cur = nw; run = 0; since = 0; sc = 1'b1;
            end
          end
        end
      end
      if (armed) exp_q.push_back({sc, 3'(cur), 8'(1 << cur)});
    end
  end

  // scoreboard compare
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_state", int'(bus.emotional_state), int'(e[7:0]));
        chk("sb_idx", int'(bus.emotion_idx), int'(e[10:8]));
        chk("sb_changed", int'(bus.state_changed), int'(e[11]));
      end
    end
  end

  // driver tasks
  task automatic do_tick(input logic [9:0] lv);
    @(negedge clk);
    bus.tick = 1'b1;
    bus.neurotransmitter_level = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input logic [9:0] lv, input int n);
    for (int i = 0; i < n; i++) do_tick(lv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.tick = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    bus.tick = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] lv;
    checks = 0; failures = 0; armed = 1'b0;
    rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.neurotransmitter_level = 10'h000;

    chk("model_calm", decode(LV_CALM), 0);
    chk("model_happy", decode(LV_HAPPY), 1);
    chk("model_stressed", decode(LV_STRESSED), 5);

    // reset and steady CALM
    do_reset(2);
    chk("reset_state", int'(bus.emotional_state), 8'h01);
    chk("reset_idx", int'(bus.emotion_idx), 0);
    chk("reset_changed", int'(bus.state_changed), 0);
    do_ticks(LV_CALM, 20);
    chk("calm_hold", int'(bus.emotional_state), 8'h01);

    // dwell gating
    do_reset(1);
    do_ticks(LV_HAPPY, 7);
    chk("dwell_t7", int'(bus.emotional_state), 8'h01);
    do_tick(LV_HAPPY);
    chk("dwell_t8_state", int'(bus.emotional_state), 8'h02);
    chk("dwell_t8_idx", int'(bus.emotion_idx), 1);
    chk("dwell_pulse", int'(bus.state_changed), 1);
    idle(1);
    chk("dwell_pulse_end", int'(bus.state_changed), 0);

    // return to CALM and let dwell saturate, then glitch filter
    do_ticks(LV_CALM, 20);
    chk("back_calm", int'(bus.emotional_state), 8'h01);
    do_ticks(LV_HAPPY, 3);
    do_tick(LV_CALM);
    do_ticks(LV_HAPPY, 3);
    chk("glitch_hold", int'(bus.emotional_state), 8'h01);
    do_tick(LV_HAPPY);
    chk("glitch_commit", int'(bus.emotional_state), 8'h02);

    // tick gating
    do_ticks(LV_HAPPY, 10);
    @(negedge clk);
    bus.neurotransmitter_level = LV_STRESSED;
    idle(50);
    chk("gate_hold", int'(bus.emotional_state), 8'h02);
    do_ticks(LV_STRESSED, 4);
    chk("gate_commit", int'(bus.emotional_state), 8'h20);

    // reset mid-pending
    do_reset(1);
    do_ticks(LV_HAPPY, 3);
    do_reset(1);
    chk("midrst_state", int'(bus.emotional_state), 8'h01);
    chk("midrst_phase", int'(bus.phase_dbg), 0);
    do_ticks(LV_HAPPY, 4);
    chk("midrst_nocommit", int'(bus.emotional_state), 8'h01);
    do_ticks(LV_HAPPY, 4);
    chk("midrst_commit", int'(bus.emotional_state), 8'h02);

    // stress bypass
    do_reset(1);
    do_tick(LV_STRESSED);
`ifdef EMOTION_STRESS_BYPASS_EN
    chk("bypass_t1", int'(bus.emotional_state), 8'h20);
    chk("bypass_pulse", int'(bus.state_changed), 1);
`else
    chk("nobypass_t1", int'(bus.emotional_state), 8'h01);
    do_ticks(LV_STRESSED, 6);
    chk("nobypass_t7", int'(bus.emotional_state), 8'h01);
    do_tick(LV_STRESSED);
    chk("nobypass_t8", int'(bus.emotional_state), 8'h20);
`endif

    // random traffic
    do_reset(1);
    lv = LV_CALM;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      if ($urandom_range(0, 5) == 0) lv = 10'($urandom);
      if ($urandom_range(0, 9) < 7) do_tick(lv);
      else idle(1);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
